// File: rtl/video_pkg.sv
// Shared video-link definitions: pixel layout in AXI4-Stream tdata, unpacker FSM states,
// and default frame geometry.
package video_pkg;

    localparam int unsigned H_RES_DEF = 640;
    localparam int unsigned V_RES_DEF = 480;

    // tdata = {8'h00, r, g, b}
    localparam int unsigned PIX_R_LSB = 16;
    localparam int unsigned PIX_G_LSB = 8;
    localparam int unsigned PIX_B_LSB = 0;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } pixel_t;

    typedef enum logic {
        SYNC   = 1'b0,
        ACTIVE = 1'b1
    } unpack_state_t;

    function automatic pixel_t unpack_pixel(input logic [31:0] tdata);
        pixel_t p;
        p.r = tdata[PIX_R_LSB +: 8];
        p.g = tdata[PIX_G_LSB +: 8];
        p.b = tdata[PIX_B_LSB +: 8];
        return p;
    endfunction

endpackage

// File: rtl/axis_pipe_reg.sv
// Single-stage valid/ready output register of generic width; full throughput, data held
// while the consumer stalls.
module axis_pipe_reg #(
    parameter int unsigned W = 8
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic [W-1:0] s_data_i,
    input  logic         s_valid_i,
    output logic         s_ready_o,
    output logic [W-1:0] m_data_o,
    output logic         m_valid_o,
    input  logic         m_ready_i
);

    logic [W-1:0] data_q;
    logic         valid_q;

    assign s_ready_o = rst_ni && (!valid_q || m_ready_i);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else if (s_ready_o) begin
            valid_q <= s_valid_i;
            if (s_valid_i) begin
                data_q <= s_data_i;
            end
        end
    end

    assign m_data_o  = data_q;
    assign m_valid_o = valid_q;

endmodule

// File: rtl/stream_unpacker.sv
// AXI4-Stream video receiver: frame lock, x/y tracking, framing checks and resync.
// Optional saturating error counter enabled by defining STREAM_UNPACKER_ERR_CNT_EN.
module stream_unpacker
    import video_pkg::*;
#(
    parameter int unsigned H_RES = H_RES_DEF,
    parameter int unsigned V_RES = V_RES_DEF,
    parameter int unsigned X_W   = 10,
    parameter int unsigned Y_W   = 9
) (
    input  logic           aclk,
    input  logic           aresetn,
    input  logic [31:0]    in_stream_tdata,
    input  logic [3:0]     in_stream_tkeep,
    input  logic           in_stream_tlast,
    input  logic           in_stream_tuser,
    input  logic           in_stream_tvalid,
    output logic           in_stream_tready,
    output logic [7:0]     r,
    output logic [7:0]     g,
    output logic [7:0]     b,
    output logic [X_W-1:0] x,
    output logic [Y_W-1:0] y,
    output logic           sof,
    output logic           eol,
    output logic           eof,
    output logic           out_valid,
    input  logic           out_ready,
    output logic           frame_done,
    output logic           err_pulse,
    output logic [15:0]    err_count
);

    localparam int unsigned DW = 24 + X_W + Y_W + 3;
    localparam logic [X_W-1:0] X_LAST = X_W'(H_RES - 1);
    localparam logic [Y_W-1:0] Y_LAST = Y_W'(V_RES - 1);

    unpack_state_t  state_q, state_d;
    logic [X_W-1:0] xc_q, xc_d;
    logic [Y_W-1:0] yc_q, yc_d;
    logic           err_q, err_d;
    logic           done_q, done_d;

    logic           accept;
    logic           fwd;
    logic [X_W-1:0] ox;
    logic [Y_W-1:0] oy;
    logic           osof, oeol, oeof;
    pixel_t         pix_in;
    logic [DW-1:0]  pipe_out;
    logic           unused_in;

    assign unused_in = ^{in_stream_tdata[31:24], in_stream_tkeep};
    assign pix_in    = unpack_pixel(in_stream_tdata);
    assign accept    = in_stream_tvalid && in_stream_tready;

    always_comb begin
        state_d = state_q;
        xc_d    = xc_q;
        yc_d    = yc_q;
        err_d   = 1'b0;
        done_d  = 1'b0;
        fwd     = 1'b0;
        ox      = xc_q;
        oy      = yc_q;
        osof    = 1'b0;
        oeol    = 1'b0;
        oeof    = 1'b0;
        if (accept) begin
            unique case (state_q)
                SYNC: begin
                    if (in_stream_tuser) begin
                        if (in_stream_tlast) begin
                            err_d = 1'b1;
                        end else begin
                            fwd     = 1'b1;
                            ox      = '0;
                            oy      = '0;
                            osof    = 1'b1;
                            xc_d    = X_W'(1);
                            yc_d    = '0;
                            state_d = ACTIVE;
                        end
                    end
                end
                ACTIVE: begin
                    if (in_stream_tuser) begin
                        // Mid-frame SOF restarts the frame on this beat rather than dropping it.
                        err_d = 1'b1;
                        fwd   = 1'b1;
                        ox    = '0;
                        oy    = '0;
                        osof  = 1'b1;
                        xc_d  = X_W'(1);
                        yc_d  = '0;
                    end else if (in_stream_tlast != (xc_q == X_LAST)) begin
                        err_d   = 1'b1;
                        state_d = SYNC;
                    end else if (in_stream_tlast) begin
                        fwd  = 1'b1;
                        oeol = 1'b1;
                        xc_d = '0;
                        if (yc_q == Y_LAST) begin
                            oeof    = 1'b1;
                            done_d  = 1'b1;
                            yc_d    = '0;
                            state_d = SYNC;
                        end else begin
                            yc_d = yc_q + Y_W'(1);
                        end
                    end else begin
                        fwd  = 1'b1;
                        xc_d = xc_q + X_W'(1);
                    end
                end
                default: state_d = SYNC;
            endcase
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q <= SYNC;
            xc_q    <= '0;
            yc_q    <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            xc_q    <= xc_d;
            yc_q    <= yc_d;
            err_q   <= err_d;
            done_q  <= done_d;
        end
    end

    axis_pipe_reg #(
        .W (DW)
    ) u_out_reg (
        .clk_i     (aclk),
        .rst_ni    (aresetn),
        .s_data_i  ({pix_in, ox, oy, osof, oeol, oeof}),
        .s_valid_i (fwd),
        .s_ready_o (in_stream_tready),
        .m_data_o  (pipe_out),
        .m_valid_o (out_valid),
        .m_ready_i (out_ready)
    );

    assign {r, g, b, x, y, sof, eol, eof} = pipe_out;
    assign err_pulse  = err_q;
    assign frame_done = done_q;

`ifdef STREAM_UNPACKER_ERR_CNT_EN
    logic [15:0] err_cnt_q;

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            err_cnt_q <= '0;
        end else if (err_d && (err_cnt_q != '1)) begin
            err_cnt_q <= err_cnt_q + 16'd1;
        end
    end

    assign err_count = err_cnt_q;
`else
    assign err_count = '0;
`endif

endmodule

// File: tb/tb_stream_unpacker.sv
// Scoreboard bench for stream_unpacker at H_RES=4, V_RES=3.
module tb_stream_unpacker;

`ifdef STREAM_UNPACKER_ERR_CNT_EN
    localparam bit EC_EN = 1'b1;
`else
    localparam bit EC_EN = 1'b0;
`endif

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic [31:0] tdata = '0;
    logic [3:0]  tkeep = '1;
    logic        tlast = 1'b0;
    logic        tuser = 1'b0;
    logic        tvalid = 1'b0;
    logic        tready;
    logic [7:0]  r, g, b;
    logic [1:0]  x, y;
    logic        sof, eol, eof;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        frame_done, err_pulse;
    logic [15:0] err_count;

    stream_unpacker #(
        .H_RES (4),
        .V_RES (3),
        .X_W   (2),
        .Y_W   (2)
    ) dut (
        .aclk             (aclk),
        .aresetn          (aresetn),
        .in_stream_tdata  (tdata),
        .in_stream_tkeep  (tkeep),
        .in_stream_tlast  (tlast),
        .in_stream_tuser  (tuser),
        .in_stream_tvalid (tvalid),
        .in_stream_tready (tready),
        .r                (r),
        .g                (g),
        .b                (b),
        .x                (x),
        .y                (y),
        .sof              (sof),
        .eol              (eol),
        .eof              (eof),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .frame_done       (frame_done),
        .err_pulse        (err_pulse),
        .err_count        (err_count)
    );

    always #5 aclk = ~aclk;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
        logic [1:0] x;
        logic [1:0] y;
        logic       sof;
        logic       eol;
        logic       eof;
    } exp_t;

    exp_t        sb[$];
    int unsigned total = 0;
    int unsigned bad = 0;
    int unsigned err_seen = 0;
    int unsigned done_seen = 0;
    int unsigned exp_err = 0;
    int unsigned exp_done = 0;
    int unsigned exp_ec = 0;
    int unsigned seq = 0;
    logic [7:0]  last_r;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h @%0t", name, act, exp, $time);
        end
    endtask

    always @(negedge aclk) begin
        if (aresetn && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_pixel: got x=%0d y=%0d r=%0h expected none", x, y, r);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("pixel", 64'({r, g, b, x, y, sof, eol, eof}), 64'(e));
            end
        end
        if (err_pulse)  err_seen++;
        if (frame_done) done_seen++;
    end

    task automatic send(input logic user, input logic last, input logic fwd,
                        input logic [1:0] ex, input logic [1:0] ey,
                        input logic esof, input logic eeol, input logic eeof);
        logic [7:0] pr, pg, pb;
        int unsigned n;
        pr = 8'(seq);
        pg = 8'(seq * 3 + 1);
        pb = ~pr;
        seq++;
        tdata  = {8'hA5, pr, pg, pb};
        tuser  = user;
        tlast  = last;
        tvalid = 1'b1;
        last_r = pr;
        if (fwd) sb.push_back('{pr, pg, pb, ex, ey, esof, eeol, eeof});
        n = 0;
        do begin
            @(negedge aclk);
            n++;
        end while (!tready && n < 50);
        if (!tready) check("accept_timeout", 64'(tready), 64'(1));
        @(posedge aclk);
        #1;
    endtask

    task automatic hold_check(input logic [1:0] ex, input logic [1:0] ey);
        tvalid    = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge aclk);
            check("bp_tready", 64'(tready), 64'(0));
            check("bp_hold", 64'({out_valid, x, y, r}), 64'({1'b1, ex, ey, last_r}));
        end
        @(posedge aclk);
        #1;
        out_ready = 1'b1;
    endtask

    task automatic send_beats(input int unsigned first, input int unsigned last_i,
                              input int pause_at);
        for (int unsigned i = first; i <= last_i; i++) begin
            logic [1:0] xi, yi;
            xi = 2'(i % 4);
            yi = 2'(i / 4);
            send(i == 0, xi == 2'd3, 1'b1, xi, yi, i == 0, xi == 2'd3, i == 11);
            if (int'(i) == pause_at) hold_check(xi, yi);
        end
    endtask

    task automatic drain();
        int unsigned n;
        tvalid = 1'b0;
        n = 0;
        while (sb.size() != 0 && n < 30) begin
            @(negedge aclk);
            n++;
        end
        check("drain", 64'(sb.size()), 64'(0));
        repeat (3) @(posedge aclk);
        #1;
    endtask

    task automatic end_checks();
        check("err_pulses", 64'(err_seen), 64'(exp_err));
        check("frame_done", 64'(done_seen), 64'(exp_done));
        check("err_count", 64'(err_count), EC_EN ? 64'(exp_ec) : 64'(0));
    endtask

    task automatic do_reset();
        tvalid  = 1'b0;
        aresetn = 1'b0;
        repeat (2) @(posedge aclk);
        @(negedge aclk);
        check("rst_tready", 64'(tready), 64'(0));
        check("rst_outputs", 64'({out_valid, r, g, b, x, y, sof, eol, eof}), 64'(0));
        check("rst_pulses_cnt", 64'({frame_done, err_pulse, err_count}), 64'(0));
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
        exp_ec  = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();

        // Clean frame
        send_beats(0, 11, -1);
        exp_done++;
        drain();
        end_checks();

        // Back-pressure at (1,1)
        send_beats(0, 11, 5);
        exp_done++;
        drain();
        end_checks();

        // Pre-SOF junk then clean frame
        for (int i = 0; i < 5; i++) send(1'b0, i == 3, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0);
        send_beats(0, 11, -1);
        exp_done++;
        drain();
        end_checks();

        // Early EOL at (2,1), trailing junk, then clean frame
        send_beats(0, 5, -1);
        send(1'b0, 1'b1, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0);
        exp_err++;
        exp_ec++;
        send(1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0);
        send(1'b0, 1'b1, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0);
        drain();
        end_checks();
        send_beats(0, 11, -1);
        exp_done++;
        drain();
        end_checks();

        // Mid-frame SOF at (2,1)
        send_beats(0, 5, -1);
        send_beats(0, 11, -1);
        exp_err++;
        exp_ec++;
        exp_done++;
        drain();
        end_checks();

        // Reset mid-line then clean frame
        send_beats(0, 1, -1);
        drain();
        do_reset();
        send_beats(0, 11, -1);
        exp_done++;
        drain();
        end_checks();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
